// File: rtl/shift_ex_stage.sv
// Execute-stage wrapper for the RV32I shift instructions.
// Drives an external combinational barrel shifter, decodes the operation,
// picks the left or right result and queues it in a 2-entry FIFO.
// The FIFO feeds the writeback side through a valid/ready handshake.
module shift_ex_stage #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    input  logic [4:0]      imm_shamt,
    input  logic            use_imm,
    input  logic [2:0]      funct3,
    input  logic            funct7_5,
    input  logic [4:0]      rd_in,
    output logic [XLEN-1:0] sh_a,
    output logic [4:0]      sh_amt,
    output logic            sh_arith,
    input  logic [XLEN-1:0] sh_res_l,
    input  logic [XLEN-1:0] sh_res_r,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_result,
    output logic [4:0]      out_rd,
    output logic            out_illegal
);

    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;

    // FIFO storage and bookkeeping; pointers are 1 bit and wrap modulo 2
    logic [XLEN-1:0] r_res [DEPTH];
    logic [4:0]      r_rd  [DEPTH];
    logic            r_ill [DEPTH];
    logic [1:0]      r_count;
    logic            r_wptr;
    logic            r_rptr;

    logic [4:0]      w_amt;
    logic [XLEN-1:0] w_result;
    logic            w_illegal;
    logic            w_in_ready;
    logic            w_push;
    logic            w_pop;

    // Only the low five bits of rs2 form a shift amount
    logic w_unused_rs2;
    assign w_unused_rs2 = ^rs2_data[XLEN-1:5];

    // Shifter drive: arithmetic select only for funct3=101 with bit 30 set
    always_comb begin
        w_amt    = use_imm ? imm_shamt : rs2_data[4:0];
        sh_a     = rs1_data;
        sh_amt   = w_amt;
        sh_arith = (funct3 == F3_SR) && funct7_5;
    end

    // Decode: choose the shifter side, flag anything that is not SLL/SRL/SRA.
    // A zero amount bypasses the shifter so the operand passes through unchanged.
    always_comb begin
        w_result  = '0;
        w_illegal = 1'b0;
        if (funct3 == F3_SLL && !funct7_5) begin
            w_result = (w_amt == 5'd0) ? rs1_data : sh_res_l;
        end else if (funct3 == F3_SR) begin
            w_result = (w_amt == 5'd0) ? rs1_data : sh_res_r;
        end else begin
            w_illegal = 1'b1;
        end
    end

    // Handshake: accept while there is room and no flush is in progress
    always_comb begin
        w_in_ready  = (r_count < 2'd2) && !flush;
        w_push      = in_valid && w_in_ready;
        w_pop       = (r_count != 2'd0) && out_ready;
        in_ready    = w_in_ready;
        out_valid   = (r_count != 2'd0);
        out_result  = r_res[r_rptr];
        out_rd      = r_rd[r_rptr];
        out_illegal = r_ill[r_rptr];
    end

    // FIFO update: reset clears everything, flush empties, else push/pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= 2'd0;
            r_wptr  <= 1'b0;
            r_rptr  <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                r_res[i] <= '0;
                r_rd[i]  <= '0;
                r_ill[i] <= 1'b0;
            end
        end else begin
            if (w_push) begin
                r_res[r_wptr] <= w_result;
                r_rd[r_wptr]  <= rd_in;
                r_ill[r_wptr] <= w_illegal;
            end
            if (flush) begin
                // A pop in this cycle has already been seen downstream
                r_count <= 2'd0;
                r_wptr  <= 1'b0;
                r_rptr  <= 1'b0;
            end else begin
                if (w_push) r_wptr <= ~r_wptr;
                if (w_pop)  r_rptr <= ~r_rptr;
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 2'd1;
                    2'b01:   r_count <= r_count - 2'd1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_shift_ex_stage.sv
// Bench for shift_ex_stage: table of directed shift vectors, hand-written
// backpressure / flush / reset sequences, then randomized traffic, all
// compared against a queue-based reference model of the stage.
module tb_shift_ex_stage;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  imm_shamt;
    logic        use_imm;
    logic [2:0]  funct3;
    logic        funct7_5;
    logic [4:0]  rd_in;
    logic [31:0] sh_a;
    logic [4:0]  sh_amt;
    logic        sh_arith;
    logic [31:0] sh_res_l;
    logic [31:0] sh_res_r;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic [4:0]  out_rd;
    logic        out_illegal;

    int n_checks = 0;
    int n_errors = 0;

    shift_ex_stage dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .imm_shamt  (imm_shamt),
        .use_imm    (use_imm),
        .funct3     (funct3),
        .funct7_5   (funct7_5),
        .rd_in      (rd_in),
        .sh_a       (sh_a),
        .sh_amt     (sh_amt),
        .sh_arith   (sh_arith),
        .sh_res_l   (sh_res_l),
        .sh_res_r   (sh_res_r),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_result (out_result),
        .out_rd     (out_rd),
        .out_illegal(out_illegal)
    );

    // Behavioural barrel shifter standing in for the real datapath
    assign sh_res_l = sh_a << sh_amt;
    assign sh_res_r = sh_arith ? 32'($signed(sh_a) >>> sh_amt) : (sh_a >> sh_amt);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  rd;
        logic        ill;
    } exp_t;

    exp_t model_q[$];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Architectural meaning of one shift instruction
    function automatic exp_t ref_op(input logic [2:0] f3, input logic f7, input logic [31:0] a,
                                    input logic [31:0] b, input logic [4:0] imm,
                                    input logic ui, input logic [4:0] rd);
        exp_t e;
        int   amt;
        amt   = ui ? int'(imm) : int'(b % 32);
        e.rd  = rd;
        e.ill = 1'b0;
        e.res = 32'd0;
        if (f3 == 3'd1 && f7 == 1'b0)      e.res = a << amt;
        else if (f3 == 3'd5 && f7 == 1'b0) e.res = a >> amt;
        else if (f3 == 3'd5 && f7 == 1'b1) e.res = 32'($signed(a) >>> amt);
        else                               e.ill = 1'b1;
        return e;
    endfunction

    function automatic logic model_ready();
        return (model_q.size() < 2) && !flush;
    endfunction

    // Compare every observable output with the model (called mid-cycle)
    task automatic check_model();
        exp_t h;
        chk("in_ready", 32'(in_ready), 32'(model_ready()));
        chk("out_valid", 32'(out_valid), 32'(model_q.size() > 0));
        if (model_q.size() > 0) begin
            h = model_q[0];
            chk("out_result", out_result, h.res);
            chk("out_rd", 32'(out_rd), 32'(h.rd));
            chk("out_illegal", 32'(out_illegal), 32'(h.ill));
        end
        chk("sh_a", sh_a, rs1_data);
        chk("sh_amt", 32'(sh_amt), use_imm ? 32'(imm_shamt) : 32'(rs2_data % 32));
        chk("sh_arith", 32'(sh_arith), 32'(funct3 == 3'd5 && funct7_5 == 1'b1));
    endtask

    // Advance the model across one rising edge using the applied inputs
    task automatic tick();
        logic rdy;
        logic do_pop;
        @(posedge clk);
        rdy    = model_ready();
        do_pop = (model_q.size() > 0) && out_ready;
        if (do_pop) void'(model_q.pop_front());
        if (flush) model_q.delete();
        else if (in_valid && rdy)
            model_q.push_back(ref_op(funct3, funct7_5, rs1_data, rs2_data, imm_shamt, use_imm, rd_in));
        #1;
    endtask

    task automatic step();
        @(negedge clk);
        check_model();
        tick();
    endtask

    task automatic set_op(input logic [2:0] f3, input logic f7, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] imm, input logic ui,
                          input logic [4:0] rd);
        funct3 = f3; funct7_5 = f7; rs1_data = a; rs2_data = b;
        imm_shamt = imm; use_imm = ui; rd_in = rd;
    endtask

    typedef struct {
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [4:0]  imm;
        logic        ui;
        logic [4:0]  rd;
        logic [31:0] exp_res;
        logic        exp_ill;
    } vec_t;

    vec_t vecs[10];

    initial begin
        vecs[0] = '{3'b001, 1'b0, 32'h0000_0001, 32'd31,         5'd0, 1'b0, 5'd5,  32'h8000_0000, 1'b0};
        vecs[1] = '{3'b101, 1'b1, 32'h8000_0000, 32'd0,          5'd4, 1'b1, 5'd6,  32'hF800_0000, 1'b0};
        vecs[2] = '{3'b101, 1'b0, 32'h8000_0000, 32'd0,          5'd4, 1'b1, 5'd7,  32'h0800_0000, 1'b0};
        vecs[3] = '{3'b101, 1'b1, 32'h8000_0000, 32'd0,          5'd0, 1'b1, 5'd8,  32'h8000_0000, 1'b0};
        vecs[4] = '{3'b101, 1'b0, 32'h8000_0000, 32'd0,          5'd0, 1'b1, 5'd9,  32'h8000_0000, 1'b0};
        vecs[5] = '{3'b001, 1'b1, 32'h1234_5678, 32'd3,          5'd0, 1'b0, 5'd10, 32'h0000_0000, 1'b1};
        vecs[6] = '{3'b010, 1'b0, 32'h1234_5678, 32'd3,          5'd0, 1'b0, 5'd11, 32'h0000_0000, 1'b1};
        vecs[7] = '{3'b001, 1'b0, 32'h0000_0003, 32'd1,          5'd0, 1'b0, 5'd12, 32'h0000_0006, 1'b0};
        vecs[8] = '{3'b101, 1'b1, 32'h7000_0000, 32'h0000_0025,  5'd0, 1'b0, 5'd13, 32'h0380_0000, 1'b0};
        vecs[9] = '{3'b001, 1'b0, 32'hDEAD_BEEF, 32'd0,          5'd8, 1'b1, 5'd31, 32'hADBE_EF00, 1'b0};

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        set_op(3'b001, 1'b0, 32'd0, 32'd0, 5'd0, 1'b0, 5'd0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        // Reset state
        chk("rst out_valid", 32'(out_valid), 32'd0);
        chk("rst out_result", out_result, 32'd0);
        chk("rst out_rd", 32'(out_rd), 32'd0);
        chk("rst out_illegal", 32'(out_illegal), 32'd0);
        chk("rst in_ready", 32'(in_ready), 32'd1);

        // Directed vectors: push one op, check it at the head the next cycle
        for (int v = 0; v < 10; v++) begin
            set_op(vecs[v].f3, vecs[v].f7, vecs[v].rs1, vecs[v].rs2, vecs[v].imm, vecs[v].ui, vecs[v].rd);
            in_valid = 1'b1; out_ready = 1'b1;
            step();
            in_valid = 1'b0;
            @(negedge clk);
            check_model();
            chk($sformatf("vec%0d valid", v), 32'(out_valid), 32'd1);
            chk($sformatf("vec%0d result", v), out_result, vecs[v].exp_res);
            chk($sformatf("vec%0d rd", v), 32'(out_rd), 32'(vecs[v].rd));
            chk($sformatf("vec%0d illegal", v), 32'(out_illegal), 32'(vecs[v].exp_ill));
            tick();
            $display("vector %0d: f3=%b f7=%b rs1=%h -> %h ill=%b", v, vecs[v].f3, vecs[v].f7,
                     vecs[v].rs1, out_result, out_illegal);
        end
        step();

        // Backpressure: three ops with out_ready low, only two accepted
        out_ready = 1'b0; in_valid = 1'b1;
        set_op(3'b001, 1'b0, 32'h0000_0001, 32'd1, 5'd0, 1'b0, 5'd1); step();
        set_op(3'b001, 1'b0, 32'h0000_0001, 32'd2, 5'd0, 1'b0, 5'd2); step();
        set_op(3'b001, 1'b0, 32'h0000_0001, 32'd3, 5'd0, 1'b0, 5'd3);
        @(negedge clk);
        chk("full in_ready", 32'(in_ready), 32'd0);
        check_model(); tick();
        out_ready = 1'b1;
        @(negedge clk);
        chk("first out rd", 32'(out_rd), 32'd1);
        chk("first out result", out_result, 32'h2);
        check_model(); tick();
        @(negedge clk);
        chk("ready after pop", 32'(in_ready), 32'd1);
        chk("second out rd", 32'(out_rd), 32'd2);
        check_model(); tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("third out rd", 32'(out_rd), 32'd3);
        chk("third out result", out_result, 32'h8);
        check_model(); tick();
        step();
        $display("backpressure sequence done");

        // Flush with two entries buffered and an op offered
        out_ready = 1'b0; in_valid = 1'b1;
        set_op(3'b101, 1'b0, 32'hFFFF_0000, 32'd4, 5'd0, 1'b0, 5'd20); step();
        set_op(3'b101, 1'b1, 32'hFFFF_0000, 32'd4, 5'd0, 1'b0, 5'd21); step();
        flush = 1'b1;
        step();
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        chk("post flush out_valid", 32'(out_valid), 32'd0);
        check_model(); tick();
        set_op(3'b001, 1'b0, 32'h0000_0003, 32'd1, 5'd0, 1'b0, 5'd22);
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("post flush sll", out_result, 32'h6);
        chk("post flush rd", 32'(out_rd), 32'd22);
        check_model(); tick();
        $display("flush sequence done");

        // Reset asserted between edges with two results buffered
        out_ready = 1'b0; in_valid = 1'b1;
        set_op(3'b001, 1'b0, 32'h0000_00FF, 32'd4, 5'd0, 1'b0, 5'd17); step();
        set_op(3'b001, 1'b0, 32'h0000_00FF, 32'd8, 5'd0, 1'b0, 5'd18); step();
        in_valid = 1'b0;
        #3 rst_n = 1'b0;
        #1;
        chk("async rst out_valid", 32'(out_valid), 32'd0);
        chk("async rst out_result", out_result, 32'd0);
        chk("async rst out_rd", 32'(out_rd), 32'd0);
        chk("async rst out_illegal", 32'(out_illegal), 32'd0);
        model_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        set_op(3'b101, 1'b1, 32'h8000_0000, 32'd1, 5'd0, 1'b0, 5'd25);
        in_valid = 1'b1; out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        @(negedge clk);
        chk("after rst first result", out_result, 32'hC000_0000);
        chk("after rst first rd", 32'(out_rd), 32'd25);
        check_model(); tick();
        $display("mid-stream reset sequence done");

        // Randomized traffic against the reference model
        for (int c = 0; c < 400; c++) begin
            int sel;
            sel = int'($urandom_range(0, 3));
            case (sel)
                0:       funct3 = 3'b001;
                1, 2:    funct3 = 3'b101;
                default: funct3 = 3'($urandom);
            endcase
            funct7_5  = ($urandom_range(0, 3) == 0);
            rs1_data  = $urandom;
            rs2_data  = ($urandom_range(0, 5) == 0) ? 32'd0 : $urandom;
            imm_shamt = ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom);
            use_imm   = 1'($urandom);
            rd_in     = 5'($urandom);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            flush     = ($urandom_range(0, 19) == 0);
            step();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        step(); step(); step();
        $display("random phase done");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/shift_ex_stage.md
Name: shift_ex_stage

Overview:
Execute-stage wrapper for RV32I shift instructions (SLL/SRL/SRA/SLLI/SRLI/SRAI).
- Decodes funct3/funct7 and selects the shift amount.
- Drives the combinational 32-bit barrel shifter and captures its left/right results.
- Delivers each result to the EX/MEM side through a valid/ready handshake with a 2-entry output buffer.
- Sits between the issue logic (upstream) and writeback arbitration (downstream).

Parameters:
XLEN, 32, data width. Fixed at 32 because the shifter takes a 5-bit amount.
DEPTH, 2, output buffer entries. Only 2 is supported.

Ports:
clk  input  1  clock, all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  pipeline flush (branch mispredict/trap)
in_valid  input  1  upstream operation valid
in_ready  output  1  stage can accept an operation this cycle
rs1_data  input  32  value to shift
rs2_data  input  32  register shift amount source, bits [4:0] used
imm_shamt  input  5  immediate shift amount
use_imm  input  1  1 selects imm_shamt, 0 selects rs2_data[4:0]
funct3  input  3  instruction funct3
funct7_5  input  1  instruction bit 30
rd_in  input  5  destination register tag
sh_a  output  32  to shifter data input (= rs1_data)
sh_amt  output  5  to shifter amount input
sh_arith  output  1  to shifter arithmetic select
sh_res_l  input  32  shifter left-shift result
sh_res_r  input  32  shifter right-shift result
out_valid  output  1  buffer head valid
out_ready  input  1  downstream accepts head
out_result  output  32  head result
out_rd  output  5  head destination tag
out_illegal  output  1  head was an undecodable shift encoding

Behaviour:
- Reset (rst_n=0, asynchronous): count=0, all buffer entries zeroed; out_valid=0, out_result=0, out_rd=0, out_illegal=0. in_ready is 1 after reset deasserts.
- Shifter drive (combinational, every cycle):
  - sh_a = rs1_data.
  - sh_amt = use_imm ? imm_shamt : rs2_data[4:0].
  - sh_arith = (funct3==3'b101 && funct7_5).
- Decode at accept:
  - funct3=001, funct7_5=0 -> SLL, result = sh_res_l.
  - funct3=101, funct7_5=0 -> SRL, result = sh_res_r.
  - funct3=101, funct7_5=1 -> SRA, result = sh_res_r.
  - Any other combination -> illegal=1, result=0.
  - Amount 0 -> result = rs1_data for every legal op.
- Handshake:
  - push = in_valid && in_ready. pop = out_valid && out_ready.
  - in_ready = (count<2) && !flush. Combinational, no dependence on out_ready.
  - Latency: an operation accepted in cycle N appears at the head (out_valid=1) in cycle N+1 when the buffer was empty.
  - Order is strictly FIFO.
- Buffer counter:
  - count 0..2; out_valid = (count!=0).
  - push only: count+1. pop only: count-1. Push and pop together: count unchanged, new entry written behind the head.
  - count==2: in_ready=0, no push possible; pop drops count to 1 and in_ready rises the next cycle.
  - Head outputs hold stable while out_valid=1 and out_ready=0.
- Flush (synchronous, highest priority):
  - Next edge: count=0, out_valid=0.
  - in_ready=0 during the flush cycle, so no operation is accepted.
  - A pop coinciding with flush still completes in that cycle.
  - Entry data need not be cleared.
- Reset asserted mid-operation: all state cleared immediately; any buffered results are discarded.
- Pointer wrap: read/write pointers are 1 bit and wrap modulo 2.

Test Plan:
- Reset, then SLL with rs1=0x0000_0001, rs2=31, use_imm=0, rd=5 -> cycle after accept: out_valid=1, out_result=0x8000_0000, out_rd=5, out_illegal=0.
- SRAI rs1=0x8000_0000, imm=4, funct7_5=1 -> 0xF800_0000. SRLI on the same operands -> 0x0800_0000. Amount 0 -> 0x8000_0000 for both.
- Hold out_ready=0 and push 3 ops -> first two accepted, in_ready=0 in the third cycle. Raise out_ready -> results emerge in order, and in_ready=1 the cycle after the first pop.
- funct3=001 with funct7_5=1 -> out_illegal=1, out_result=0. funct3=010 -> out_illegal=1.
- Buffer holding 2 entries, assert flush for 1 cycle with in_valid=1 -> next cycle out_valid=0 and the input is not accepted. A following SLL (rs1=3, amount 1) yields 6.
- Assert rst_n=0 mid-stream between clock edges -> outputs zero immediately. After release, first accepted op is the first output.
